agc_controller: RTL and testbench

Closed-loop automatic gain control for the receive path. Consumes the uncorrected detector level (the same `signal_dB_i` stream that feeds gain correction) and drives the amplifier gain code, in 4 dB steps, that gain correction later subtracts. Each iteration averages a block of samples, compares the average against a target window, and steps the gain. After every gain change it waits a fixed amplifier settling time before measuring again.

---
 rtl/agc_pkg.sv | 17 +
 rtl/agc_averager.sv | 39 +++
 rtl/agc_controller.sv | 147 ++++++++++++++
 tb/tb_agc_controller.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/agc_pkg.sv
// Shared AGC types and gain-code scaling used by AGC and gain correction.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package agc_pkg;

    typedef enum logic [1:0] {
        SETTLE,
        ACCUM,
        DECIDE
    } state_t;

    typedef logic signed [5:0] gain_code_t;

    // One gain code LSB equals this many dB at the amplifier.
    localparam int GAIN_STEP_DB = 4;

endpackage

// File: rtl/agc_averager.sv
// Block averager: sums 2^AVG_LOG2 accepted detector samples and flags the last one.
// Latency: done is combinational with the final accepted sample; avg is valid the cycle after.
// Backpressure: none; every qualified sample is absorbed, clear has priority.
module agc_averager
    import agc_pkg::*;
#(
    parameter int AVG_LOG2 = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       valid,
    input  logic [7:0] sample,
    output logic       done,
    output logic [7:0] avg
);

    localparam int SUM_W = 8 + AVG_LOG2;

    logic [SUM_W-1:0]    sum;
    logic [AVG_LOG2-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
            cnt <= '0;
        end else if (clear) begin
            sum <= '0;
            cnt <= '0;
        end else if (valid) begin
            sum <= sum + SUM_W'(sample);
            cnt <= cnt + AVG_LOG2'(1);
        end
    end

    assign done = valid && !clear && (cnt == '1);
    assign avg  = sum[SUM_W-1:AVG_LOG2];

endmodule

// File: rtl/agc_controller.sv
// Closed-loop AGC: averages detector level, steps the gain code toward a target window.
// Latency: gain/update/lock registered one edge after the last sample of a block.
// Backpressure: none; samples outside ACCUM are dropped, enable low freezes the gain.
module agc_controller
    import agc_pkg::*;
#(
    parameter int TARGET_DB     = 160,
    parameter int HYST_DB       = 6,
    parameter int AVG_LOG2      = 3,
    parameter int SETTLE_CYCLES = 256,
    parameter int MAX_STEP      = 4,
    parameter int GAIN_MIN      = -8,
    parameter int GAIN_MAX      = 15,
    parameter int GAIN_INIT     = 0,
    parameter int LOCK_COUNT    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable_i,
    input  logic [7:0]        signal_dB_i,
    input  logic              valid_i,
    output logic signed [5:0] gain_dB_o,
    output logic              gain_update_o,
    output logic              locked_o
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam int LCK_W = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [LCK_W-1:0] LOCK_FULL   = LCK_W'(LOCK_COUNT);
    localparam logic signed [9:0] TGT  = 10'(TARGET_DB);
    localparam logic signed [9:0] HYST = 10'(HYST_DB);
    localparam logic signed [9:0] STEP = 10'(MAX_STEP);
    localparam logic signed [9:0] GMIN = 10'(GAIN_MIN);
    localparam logic signed [9:0] GMAX = 10'(GAIN_MAX);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  settle_cnt, settle_nxt;
    logic [LCK_W-1:0]  lock_cnt, lock_nxt;
    gain_code_t        gain, gain_nxt;
    logic              update_nxt, locked_nxt;

    logic              avg_clear, avg_valid, avg_done;
    logic [7:0]        avg;
    logic signed [9:0] err, err_mag, delta, cand, gain_ext;

    assign avg_clear = !enable_i || (state != ACCUM);
    assign avg_valid = enable_i && valid_i && (state == ACCUM);

    agc_averager #(
        .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (avg_clear),
        .valid  (avg_valid),
        .sample (signal_dB_i),
        .done   (avg_done),
        .avg    (avg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= SETTLE;
            settle_cnt    <= SETTLE_LOAD;
            lock_cnt      <= '0;
            gain          <= gain_code_t'(GAIN_INIT);
            gain_update_o <= 1'b0;
            locked_o      <= 1'b0;
        end else begin
            state         <= state_nxt;
            settle_cnt    <= settle_nxt;
            lock_cnt      <= lock_nxt;
            gain          <= gain_nxt;
            gain_update_o <= update_nxt;
            locked_o      <= locked_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        settle_nxt = settle_cnt;
        lock_nxt   = lock_cnt;
        gain_nxt   = gain;
        update_nxt = 1'b0;
        locked_nxt = locked_o;

        gain_ext = {{4{gain[5]}}, gain};
        err      = $signed({2'b00, avg}) - TGT;
        err_mag  = (err < 0) ? -err : err;
        // Signed division truncates toward zero, as the step rule wants.
        delta    = err / 10'sd4;
        if (delta > STEP)       delta = STEP;
        else if (delta < -STEP) delta = -STEP;
        cand = gain_ext - delta;
        if (cand > GMAX)      cand = GMAX;
        else if (cand < GMIN) cand = GMIN;

        if (!enable_i) begin
            state_nxt  = SETTLE;
            settle_nxt = SETTLE_LOAD;
            lock_nxt   = '0;
            locked_nxt = 1'b0;
        end else begin
            case (state)
                SETTLE: begin
                    // Leaving on the count-1 edge makes the first eligible sample land exactly SETTLE_CYCLES edges later.
                    if (settle_cnt <= CNT_W'(1)) begin
                        settle_nxt = '0;
                        state_nxt  = ACCUM;
                    end else begin
                        settle_nxt = settle_cnt - CNT_W'(1);
                    end
                end
                ACCUM: begin
                    if (avg_done) state_nxt = DECIDE;
                end
                DECIDE: begin
                    if (err_mag <= HYST) begin
                        lock_nxt   = (lock_cnt == LOCK_FULL) ? LOCK_FULL : lock_cnt + LCK_W'(1);
                        locked_nxt = (lock_nxt == LOCK_FULL);
                        state_nxt  = ACCUM;
                    end else begin
                        lock_nxt   = '0;
                        locked_nxt = 1'b0;
                        if (cand != gain_ext) begin
                            gain_nxt   = cand[5:0];
                            update_nxt = 1'b1;
                            settle_nxt = SETTLE_LOAD;
                            state_nxt  = SETTLE;
                        end else begin
                            state_nxt = ACCUM;
                        end
                    end
                end
                default: begin
                    state_nxt  = SETTLE;
                    settle_nxt = SETTLE_LOAD;
                end
            endcase
        end
    end

    assign gain_dB_o = gain;

endmodule

// File: tb/tb_agc_controller.sv
// Directed bench for agc_controller: settle timing, stepping, rails, lock, enable and reset.
// Cycle numbers count rising edges since reset release.
module tb_agc_controller;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable_i;
    logic [7:0]        signal_dB_i;
    logic              valid_i;
    logic signed [5:0] gain_dB_o;
    logic              gain_update_o;
    logic              locked_o;

    int n_cmp   = 0;
    int n_err   = 0;
    int cyc     = 0;
    int upd_cnt = 0;
    bit sparse  = 1'b0;

    always #5 clk = ~clk;

    agc_controller dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable_i      (enable_i),
        .signal_dB_i   (signal_dB_i),
        .valid_i       (valid_i),
        .gain_dB_o     (gain_dB_o),
        .gain_update_o (gain_update_o),
        .locked_o      (locked_o)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        valid_i = !sparse || (((cyc + 1) % 5) == 0);
        @(posedge clk);
        #1;
        cyc++;
        if (gain_update_o) upd_cnt++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, "_rst_gain"}, int'(gain_dB_o), 0);
        check({tag, "_rst_upd"}, int'(gain_update_o), 0);
        check({tag, "_rst_lock"}, int'(locked_o), 0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        cyc     = 0;
        upd_cnt = 0;
    endtask

    task automatic wait_update(input string tag, input int exp_cyc, input int limit);
        int i = 0;
        do begin
            step();
            i++;
        end while (!gain_update_o && i < limit);
        if (!gain_update_o) check({tag, "_timeout"}, -1, exp_cyc);
        else                check(tag, cyc, exp_cyc);
    endtask

    initial begin
        rst_n       = 1'b0;
        enable_i    = 1'b1;
        valid_i     = 1'b0;
        signal_dB_i = 8'd0;

        // Level 180: err=20, step clamped to 4 codes down.
        signal_dB_i = 8'd180;
        sparse      = 1'b0;
        do_reset("t1");
        wait_update("t1_upd1_cyc", 265, 400);
        check("t1_gain1", int'(gain_dB_o), -4);
        step();
        check("t1_pulse_width", int'(gain_update_o), 0);
        wait_update("t1_upd2_cyc", 530, 400);
        check("t1_gain2", int'(gain_dB_o), -8);

        // Level 100: climb to the upper rail, then sit there without pulses.
        signal_dB_i = 8'd100;
        do_reset("t2");
        wait_update("t2_upd1_cyc", 265, 400);
        check("t2_gain1", int'(gain_dB_o), 4);
        wait_update("t2_upd2_cyc", 530, 400);
        check("t2_gain2", int'(gain_dB_o), 8);
        wait_update("t2_upd3_cyc", 795, 400);
        check("t2_gain3", int'(gain_dB_o), 12);
        wait_update("t2_upd4_cyc", 1060, 400);
        check("t2_gain4", int'(gain_dB_o), 15);
        run_to(1400);
        check("t2_rail_upd", upd_cnt, 4);
        check("t2_rail_gain", int'(gain_dB_o), 15);
        check("t2_rail_lock", int'(locked_o), 0);

        // Level 163: in window, lock on 4th decision, then a step clears it.
        signal_dB_i = 8'd163;
        do_reset("t3");
        run_to(291);
        check("t3_lock_pre", int'(locked_o), 0);
        run_to(292);
        check("t3_lock", int'(locked_o), 1);
        check("t3_gain", int'(gain_dB_o), 0);
        check("t3_upd", upd_cnt, 0);
        signal_dB_i = 8'd180;
        run_to(300);
        check("t3_lock_hold", int'(locked_o), 1);
        wait_update("t3_step_cyc", 301, 50);
        check("t3_step_gain", int'(gain_dB_o), -4);
        check("t3_step_lock", int'(locked_o), 0);

        // Sparse valid at the window edge (err=6), then just outside (err=7).
        sparse      = 1'b1;
        signal_dB_i = 8'd166;
        do_reset("t4");
        run_to(415);
        check("t4_lock_pre", int'(locked_o), 0);
        run_to(416);
        check("t4_lock", int'(locked_o), 1);
        check("t4_gain", int'(gain_dB_o), 0);
        check("t4_upd", upd_cnt, 0);
        signal_dB_i = 8'd167;
        do_reset("t4b");
        wait_update("t4b_upd_cyc", 296, 400);
        check("t4b_gain", int'(gain_dB_o), -1);
        sparse = 1'b0;

        // Disable mid-accumulation, then reset right after an update.
        signal_dB_i = 8'd180;
        do_reset("t5");
        run_to(260);
        enable_i = 1'b0;
        run_to(270);
        check("t5_dis_gain", int'(gain_dB_o), 0);
        check("t5_dis_upd", upd_cnt, 0);
        check("t5_dis_lock", int'(locked_o), 0);
        enable_i = 1'b1;
        wait_update("t5_reen_cyc", 535, 400);
        check("t5_reen_gain", int'(gain_dB_o), -4);
        do_reset("t5b");
        wait_update("t5b_upd_cyc", 265, 400);
        check("t5b_gain", int'(gain_dB_o), -4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
